// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I control FSM with handshaked memories
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
package riscv_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_AUIPC
    } alu_op_e;
    typedef enum logic [1:0] {ALU_SRC_A_RS1, ALU_SRC_A_PC, ALU_SRC_A_ZERO} alu_src_a_e;
    typedef enum logic       {ALU_SRC_B_RS2, ALU_SRC_B_IMM} alu_src_b_e;
    typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD} mem_size_e;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} immediate_type_e;
    typedef enum logic [1:0] {PC_SRC_PC4, PC_SRC_BRANCH_JAL, PC_SRC_JALR} pc_src_e;
    typedef enum logic [1:0] {RESULT_SRC_ALU, RESULT_SRC_MEM, RESULT_SRC_PC4} result_src_e;
endpackage

module multicycle_control_unit
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          FAST_ALU_WB = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic            zero_flag_i,
    input  logic            negative_flag_i,
    input  logic            carry_flag_i,
    input  logic            overflow_flag_i,
    input  logic            imem_ready_i,
    input  logic            dmem_ready_i,
    output logic            imem_req_o,
    output logic            dmem_req_o,
    output logic            ir_write_o,
    output logic            pc_write_o,
    output pc_src_e         pc_src_o,
    output alu_op_e         alu_control_o,
    output alu_src_a_e      alu_src_a_sel_o,
    output alu_src_b_e      alu_src_b_sel_o,
    output immediate_type_e imm_src_o,
    output logic            reg_write_enable_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output mem_size_e       mem_size_o,
    output logic            mem_usign_load_o,
    output result_src_e     result_src_o,
    output logic            retire_o,
    output logic            trap_o,
    output logic [2:0]      state_o,
    output logic [31:0]     cycle_cnt_o,
    output logic [31:0]     instret_o
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
        ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5
    } state_e;

    state_e      r_state, w_next_state;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic        r_funct7_5;
    logic [31:0] r_tmo_cnt, w_tmo_next;
    logic        w_tmo_hit, w_taken, w_legal, w_is_load;
    alu_op_e     w_alu_fn;
    logic        w_unused_funct7;

    assign w_unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};
    assign w_is_load = (r_opcode == OPC_LOAD);
    assign w_tmo_hit = (MEM_TIMEOUT != 0) && (r_tmo_cnt >= MEM_TIMEOUT - 32'd1);
    assign state_o   = r_state;
    assign trap_o    = (r_state == ST_TRAP) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_FETCH;
            r_tmo_cnt  <= '0;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_funct7_5 <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_tmo_cnt <= w_tmo_next;
            if (r_state == ST_DECODE) begin
                r_opcode   <= opcode_i;
                r_funct3   <= funct3_i;
                r_funct7_5 <= funct7_i[5];
            end
        end
    end

    always_comb begin
        case (opcode_i)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: w_legal = 1'b1;
            default:                                 w_legal = 1'b0;
        endcase
    end

    // funct7[5] selects SUB only for register-register ops; shifts honour it for both classes
    always_comb begin
        w_alu_fn = ALU_ADD;
        case (r_funct3)
            3'b000: w_alu_fn = (r_opcode == OPC_OP && r_funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001: w_alu_fn = ALU_SLL;
            3'b010: w_alu_fn = ALU_SLT;
            3'b011: w_alu_fn = ALU_SLTU;
            3'b100: w_alu_fn = ALU_XOR;
            3'b101: w_alu_fn = r_funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: w_alu_fn = ALU_OR;
            default: w_alu_fn = ALU_AND;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_funct3)
            3'b000:  w_taken = zero_flag_i;
            3'b001:  w_taken = !zero_flag_i;
            3'b100:  w_taken = negative_flag_i ^ overflow_flag_i;
            3'b101:  w_taken = !(negative_flag_i ^ overflow_flag_i);
            3'b110:  w_taken = !carry_flag_i;
            3'b111:  w_taken = carry_flag_i;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state       = r_state;
        w_tmo_next         = '0;
        imem_req_o         = 1'b0;
        dmem_req_o         = 1'b0;
        ir_write_o         = 1'b0;
        pc_write_o         = 1'b0;
        pc_src_o           = PC_SRC_PC4;
        alu_control_o      = ALU_ADD;
        alu_src_a_sel_o    = ALU_SRC_A_RS1;
        alu_src_b_sel_o    = ALU_SRC_B_RS2;
        imm_src_o          = IMM_I;
        reg_write_enable_o = 1'b0;
        mem_read_o         = 1'b0;
        mem_write_o        = 1'b0;
        mem_size_o         = MEM_WORD;
        mem_usign_load_o   = 1'b0;
        result_src_o       = RESULT_SRC_ALU;
        retire_o           = 1'b0;
        if (!rst_i) begin
            case (r_state)
                ST_FETCH: begin
                    imem_req_o = 1'b1;
                    if (imem_ready_i) begin
                        ir_write_o   = 1'b1;
                        pc_write_o   = 1'b1;
                        w_next_state = ST_DECODE;
                    end else if (w_tmo_hit) begin
                        w_next_state = ST_TRAP;
                    end else if (MEM_TIMEOUT != 0) begin
                        w_tmo_next = r_tmo_cnt + 32'd1;
                    end
                end
                ST_DECODE: w_next_state = w_legal ? ST_EXEC : ST_TRAP;
                ST_EXEC: begin
                    w_next_state = ST_FETCH;
                    case (r_opcode)
                        OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM: begin
                            if (r_opcode == OPC_LUI) begin
                                alu_src_a_sel_o = ALU_SRC_A_ZERO;
                                alu_src_b_sel_o = ALU_SRC_B_IMM;
                                imm_src_o       = IMM_U;
                            end else if (r_opcode == OPC_AUIPC) begin
                                alu_control_o   = ALU_AUIPC;
                                alu_src_a_sel_o = ALU_SRC_A_PC;
                                alu_src_b_sel_o = ALU_SRC_B_IMM;
                                imm_src_o       = IMM_U;
                            end else begin
                                alu_control_o   = w_alu_fn;
                                alu_src_b_sel_o = (r_opcode == OPC_OPIMM) ? ALU_SRC_B_IMM
                                                                          : ALU_SRC_B_RS2;
                            end
                            if (FAST_ALU_WB) begin
                                reg_write_enable_o = 1'b1;
                                retire_o           = 1'b1;
                            end else begin
                                w_next_state = ST_WB;
                            end
                        end
                        OPC_BRANCH: begin
                            alu_control_o = ALU_SUB;
                            imm_src_o     = IMM_B;
                            pc_write_o    = w_taken;
                            pc_src_o      = w_taken ? PC_SRC_BRANCH_JAL : PC_SRC_PC4;
                            retire_o      = 1'b1;
                        end
                        OPC_JAL: begin
                            imm_src_o          = IMM_J;
                            pc_write_o         = 1'b1;
                            pc_src_o           = PC_SRC_BRANCH_JAL;
                            reg_write_enable_o = 1'b1;
                            result_src_o       = RESULT_SRC_PC4;
                            retire_o           = 1'b1;
                        end
                        OPC_JALR: begin
                            alu_src_b_sel_o    = ALU_SRC_B_IMM;
                            pc_write_o         = 1'b1;
                            pc_src_o           = PC_SRC_JALR;
                            reg_write_enable_o = 1'b1;
                            result_src_o       = RESULT_SRC_PC4;
                            retire_o           = 1'b1;
                        end
                        default: begin
                            alu_src_b_sel_o = ALU_SRC_B_IMM;
                            imm_src_o       = w_is_load ? IMM_I : IMM_S;
                            w_next_state    = ST_MEM;
                        end
                    endcase
                end
                ST_MEM: begin
                    dmem_req_o       = 1'b1;
                    mem_read_o       = w_is_load;
                    mem_write_o      = !w_is_load;
                    mem_size_o       = mem_size_e'(r_funct3[1:0]);
                    mem_usign_load_o = w_is_load && r_funct3[2];
                    if (dmem_ready_i) begin
                        retire_o     = !w_is_load;
                        w_next_state = w_is_load ? ST_WB : ST_FETCH;
                    end else if (w_tmo_hit) begin
                        w_next_state = ST_TRAP;
                    end else if (MEM_TIMEOUT != 0) begin
                        w_tmo_next = r_tmo_cnt + 32'd1;
                    end
                end
                ST_WB: begin
                    reg_write_enable_o = 1'b1;
                    result_src_o       = w_is_load ? RESULT_SRC_MEM : RESULT_SRC_ALU;
                    retire_o           = 1'b1;
                    w_next_state       = ST_FETCH;
                end
                default: w_next_state = ST_TRAP;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] r_cycle_cnt, r_instret;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (retire_o) r_instret <= r_instret + 32'd1;
        end
    end
    assign cycle_cnt_o = r_cycle_cnt;
    assign instret_o   = r_instret;
`else
    assign cycle_cnt_o = '0;
    assign instret_o   = '0;
`endif
endmodule
